mx11_regbank: RTL and testbench

- Register-bank end of the MX11 register bus: the write-back sink for execution-unit results and the driver of the 16x8 register line.
- Accepts a one-hot-lane data_line plus load_addr, extracts the addressed lane and commits it through a 2-stage write-back pipeline with valid/ready handshake.
- Drives committed register contents onto reg_line. Tracks pending writes in a per-register dirty scoreboard so the sequencer can hold dependent issue.

---
 rtl/mx11_regbank.sv | 118 +++++++++++
 tb/tb_mx11_regbank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mx11_regbank.sv
// mx11_regbank: register-bank end of the MX11 register bus.
// Lane-extracting write-back sink with a two-stage capture/commit pipeline,
// a per-register dirty scoreboard and a sticky illegal-class error flag.
module mx11_regbank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FLAGS_IDX  = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]     reg_line,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_line,
  input  logic [7:0]                           load_addr,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  input  logic                                 hold,
  output logic [DEPTH-1:0]                     dirty,
  output logic                                 busy,
  output logic                                 err,
  input  logic                                 err_clr
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CLS_W    = 4;
  localparam int unsigned MAX_CLS  = 1;

  // The flags register is an ordinary register, but it must exist in the bank.
  if (FLAGS_IDX >= DEPTH) begin : g_flags_idx_check
    $error("mx11_regbank: FLAGS_IDX must be below DEPTH");
  end

  // Capture stage (S1) and commit stage (S2) state.
  logic                  s1_valid;
  logic [AW-1:0]         s1_dst;
  logic [DATA_WIDTH-1:0] s1_lane;
  logic                  s2_valid;
  logic [AW-1:0]         s2_dst;
  logic [DATA_WIDTH-1:0] s2_lane;

  logic [AW-1:0]         req_dst;
  logic [CLS_W-1:0]      req_cls;
  logic                  req_legal;
  logic                  accept;
  logic                  s2_commit;
  logic                  s2_free;
  logic                  s1_adv;

  // Request decode and pipeline movement conditions.
  always_comb begin
    req_dst    = load_addr[AW-1:0];
    req_cls    = load_addr[7:4];
    req_legal  = (req_cls <= CLS_W'(MAX_CLS));
    s2_commit  = s2_valid && !hold;
    s2_free    = !s2_valid || !hold;
    s1_adv     = s1_valid && s2_free;
    load_ready = !rst && !(s1_valid && s2_valid && hold);
    accept     = load_valid && load_ready;
    busy       = s1_valid || s2_valid;
  end

  // Scoreboard: a register is dirty while either stage targets it.
  always_comb begin
    dirty = '0;
    if (s1_valid) dirty[s1_dst] = 1'b1;
    if (s2_valid) dirty[s2_dst] = 1'b1;
  end

  // Capture stage: load on a legal accept, otherwise empty when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dst   <= '0;
      s1_lane  <= '0;
    end else if (accept && req_legal) begin
      s1_valid <= 1'b1;
      s1_dst   <= req_dst;
      s1_lane  <= data_line[req_dst];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Commit stage: take S1 when free, otherwise empty after committing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_dst   <= '0;
      s2_lane  <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_dst   <= s1_dst;
      s2_lane  <= s1_lane;
    end else if (s2_commit) begin
      s2_valid <= 1'b0;
    end
  end

  // Register file write on commit; reg_line shows committed state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_line <= '0;
    end else if (s2_commit) begin
      reg_line[s2_dst] <= s2_lane;
    end
  end

  // Sticky error: an illegal accept wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && !req_legal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mx11_regbank.sv
// Directed-vector and random-stream bench for mx11_regbank.
module tb_mx11_regbank;

  logic                  clk;
  logic                  rst;
  logic [15:0][7:0]      reg_line;
  logic [15:0][7:0]      data_line;
  logic [7:0]            load_addr;
  logic                  load_valid;
  logic                  load_ready;
  logic                  hold;
  logic [15:0]           dirty;
  logic                  busy;
  logic                  err;
  logic                  err_clr;

  int checks = 0;
  int errors = 0;

  mx11_regbank #(.DATA_WIDTH(8), .DEPTH(16), .FLAGS_IDX(7)) dut (
    .clk(clk), .rst(rst), .reg_line(reg_line), .data_line(data_line),
    .load_addr(load_addr), .load_valid(load_valid), .load_ready(load_ready),
    .hold(hold), .dirty(dirty), .busy(busy), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [7:0]  d;
    logic        h;
    logic        c;
    logic        rdy;
    logic [15:0] dirty;
    logic        busy;
    logic        err;
    int          idx;
    logic [7:0]  val;
  } vec_t;

  typedef struct {
    logic [3:0] dst;
    logic [7:0] val;
  } wr_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] a, input logic [7:0] d,
                              input logic h, input logic c, input logic rdy,
                              input logic [15:0] dr, input logic b, input logic e,
                              input int idx, input logic [7:0] val);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.h = h; t.c = c; t.rdy = rdy;
    t.dirty = dr; t.busy = b; t.err = e; t.idx = idx; t.val = val;
    return t;
  endfunction

  // Background lanes carry distinct junk so the wrong-lane pick is visible.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] d,
                       input logic h, input logic c);
    for (int j = 0; j < 16; j++) data_line[j] = 8'(j * 17 + 1);
    data_line[a[3:0]] = d;
    load_valid = v;
    load_addr  = a;
    hold       = h;
    err_clr    = c;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0][7:0] model;
  logic [15:0][7:0] nxt;
  logic [7:0]       last_val [16];
  wr_t              pend[$];
  wr_t              w;
  int               accepted;
  int               cycles;
  logic             v_r;
  logic [3:0]       dst_r;
  logic [7:0]       val_r;

  initial begin
    rst = 1'b1;
    idle();

    // Reset state.
    #3;
    chk("rst_reg_line", 32'(reg_line != '0), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(load_ready), 32'd1);
    @(negedge clk);

    tbl[0]  = mk(1, 8'h13, 8'hA5, 0, 0, 1, 16'h0008, 1, 0, 3, 8'h00);
    tbl[1]  = mk(0, 8'h00, 8'h00, 0, 0, 1, 16'h0008, 1, 0, 3, 8'h00);
    tbl[2]  = mk(0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 3, 8'hA5);
    tbl[3]  = mk(1, 8'h07, 8'h11, 0, 0, 1, 16'h0080, 1, 0, 7, 8'h00);
    tbl[4]  = mk(1, 8'h17, 8'h22, 0, 0, 1, 16'h0080, 1, 0, 7, 8'h00);
    tbl[5]  = mk(0, 8'h00, 8'h00, 0, 0, 1, 16'h0080, 1, 0, 7, 8'h11);
    tbl[6]  = mk(0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 7, 8'h22);
    tbl[7]  = mk(1, 8'h01, 8'h31, 0, 0, 1, 16'h0002, 1, 0, 1, 8'h00);
    tbl[8]  = mk(1, 8'h02, 8'h32, 1, 0, 1, 16'h0006, 1, 0, 1, 8'h00);
    tbl[9]  = mk(1, 8'h03, 8'h33, 1, 0, 0, 16'h0006, 1, 0, 1, 8'h00);
    tbl[10] = mk(0, 8'h00, 8'h00, 0, 0, 1, 16'h0004, 1, 0, 1, 8'h31);
    tbl[11] = mk(0, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 2, 8'h32);
    tbl[12] = mk(1, 8'h25, 8'h77, 0, 0, 1, 16'h0000, 0, 1, 5, 8'h00);
    tbl[13] = mk(0, 8'h00, 8'h00, 0, 1, 1, 16'h0000, 0, 0, 5, 8'h00);
    tbl[14] = mk(1, 8'h2A, 8'h55, 0, 1, 1, 16'h0000, 0, 1, 10, 8'h00);
    tbl[15] = mk(0, 8'h00, 8'h00, 0, 1, 1, 16'h0000, 0, 0, 3, 8'hA5);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].c);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(load_ready), 32'(tbl[i].rdy));
      step();
      chk($sformatf("v%0d_dirty", i), 32'(dirty), 32'(tbl[i].dirty));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("v%0d_reg%0d", i, tbl[i].idx), 32'(reg_line[tbl[i].idx]), 32'(tbl[i].val));
    end

    // Async reset between edges with two writes in flight and err set.
    drive(1'b1, 8'h2F, 8'h44, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h09, 8'h99, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h0A, 8'hAA, 1'b0, 1'b0);
    step();
    idle();
    chk("pre_rst_dirty", 32'(dirty), 32'h0600);
    chk("pre_rst_err", 32'(err), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_reg_line", 32'(reg_line != '0), 32'd0);
    chk("arst_dirty", 32'(dirty), 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_ready", 32'(load_ready), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("arst_no_late_write", 32'(reg_line != '0), 32'd0);

    // Random legal stream against an in-order commit scoreboard.
    model    = '0;
    for (int j = 0; j < 16; j++) last_val[j] = 8'h00;
    accepted = 0;
    cycles   = 0;
    while ((accepted < 1000 || pend.size() > 0) && cycles < 20000) begin
      v_r   = (accepted < 1000) && ($urandom_range(0, 9) < 7);
      dst_r = 4'($urandom_range(0, 15));
      val_r = 8'($urandom_range(0, 255));
      if (val_r == last_val[dst_r]) val_r = val_r + 8'd1;
      for (int j = 0; j < 16; j++) data_line[j] = 8'($urandom_range(0, 255));
      data_line[dst_r] = val_r;
      load_valid = v_r;
      load_addr  = {3'b000, 1'($urandom_range(0, 1)), dst_r};
      hold       = ($urandom_range(0, 3) == 0) && (accepted < 1000);
      err_clr    = 1'b0;
      #1;
      if (v_r && load_ready) begin
        w.dst = dst_r;
        w.val = val_r;
        pend.push_back(w);
        last_val[dst_r] = val_r;
        accepted++;
      end
      step();
      cycles++;
      checks++;
      if (reg_line != model) begin
        nxt = model;
        if (pend.size() > 0) nxt[pend[0].dst] = pend[0].val;
        if (pend.size() > 0 && reg_line == nxt) begin
          model = nxt;
          void'(pend.pop_front());
        end else begin
          errors++;
          $display("FAIL rand_commit cycle=%0d act=%h exp=%h", cycles, reg_line, model);
          model = reg_line;
          if (pend.size() > 0) void'(pend.pop_front());
        end
      end
    end
    idle();
    chk("rand_drained", 32'(pend.size()), 32'd0);
    chk("rand_accepted", 32'(accepted), 32'd1000);
    step();
    chk("rand_final_busy", 32'(busy), 32'd0);
    chk("rand_final_regs", 32'(reg_line != model), 32'd0);
    chk("rand_err_clean", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
